// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment/anode codes shared by the seven-segment driver and capture.
//   SEG_PAT[n]  active-low a..g pattern (index 0 = segment a) that displays digit n
//   AN_CODE[n]  active-low one-cold anode code selecting digit n
//   state_t     capture FSM states
//   mul10       x*10 built from shifts, used by the BCD-to-binary conversion
package sevenseg_pkg;

    typedef logic [0:6] seg_t;

    typedef enum logic {SCAN, CONVERT} state_t;

    localparam seg_t SEG_PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    localparam logic [3:0] AN_CODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [13:0] mul10(input logic [13:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: active-low seven-segment pattern to BCD digit.
//   seg_i    active-low segments, seg_i[0] = a ... seg_i[6] = g
//   digit_o  decoded digit, 0 when the pattern is not a digit
//   err_o    high when the pattern matches no digit
module seg_decode
    import sevenseg_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] digit_o,
    output logic       err_o
);

    always_comb begin
        digit_o = 4'd0;
        err_o   = 1'b1;
        for (int i = 0; i < 10; i++)
            if (seg_i == SEG_PAT[i]) begin
                digit_o = 4'(i);
                err_o   = 1'b0;
            end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: reconstructs the value shown on a multiplexed 4-digit display.
//   clk, rst  clock and asynchronous active-high reset
//   c         active-low segments, c[0] = a ... c[6] = g
//   d         active-low one-cold anodes, d[0] = least significant digit
//   dp        active-low decimal point
//   bcd       captured digits, [3:0] = digit 0 ... [15:12] = digit 3
//   value     binary equivalent of bcd
//   dp_mask   bit n set when digit n showed its decimal point
//   valid     one-cycle pulse when bcd/value/dp_mask/err update
//   err       captured frame held at least one undecodable pattern
//   stale     no complete frame for TIMEOUT cycles
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  c,
    input  logic [3:0]  d,
    input  logic        dp,
    output logic [15:0] bcd,
    output logic [13:0] value,
    output logic [3:0]  dp_mask,
    output logic        valid,
    output logic        err,
    output logic        stale
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic [3:0]    d_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    seen_q, samp_mask;
    logic [3:0]    dig_q [4];
    logic [3:0]    dpm_q, er_q;
    logic [15:0]   bcd_q;
    logic [13:0]   value_q, value_d;
    logic [3:0]    dp_mask_q;
    logic          valid_q, err_q, stale_q;
    logic          legal, samp, dec_err;
    logic [1:0]    idx;
    logic [3:0]    dec_digit;

    seg_decode u_dec (
        .seg_i   (c),
        .digit_o (dec_digit),
        .err_o   (dec_err)
    );

    always_comb begin
        legal = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++)
            if (d == AN_CODE[i]) begin
                legal = 1'b1;
                idx   = 2'(i);
            end
    end

    // The counter only passes SETTLE-1 once per dwell, so each dwell samples exactly once.
    assign cnt_d     = (!legal || d != d_q) ? '0 : (cnt_q == CW'(SETTLE)) ? cnt_q : cnt_q + 1'b1;
    assign samp      = cnt_d == CW'(SETTLE - 1);
    assign samp_mask = samp ? 4'(4'b0001 << idx) : 4'b0000;
    assign tmo_d     = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
    assign value_d   = mul10(mul10(mul10({10'd0, dig_q[3]}) + {10'd0, dig_q[2]})
                       + {10'd0, dig_q[1]}) + {10'd0, dig_q[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCAN;
            d_q       <= 4'hF;
            cnt_q     <= '0;
            tmo_q     <= '0;
            seen_q    <= '0;
            dig_q     <= '{default: '0};
            dpm_q     <= '0;
            er_q      <= '0;
            bcd_q     <= '0;
            value_q   <= '0;
            dp_mask_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            d_q     <= d;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            if (samp) begin
                dig_q[idx] <= dec_digit;
                dpm_q[idx] <= ~dp;
                er_q[idx]  <= dec_err;
            end
            if (state_q == SCAN) begin
                tmo_q   <= tmo_d;
                stale_q <= tmo_d == TW'(TIMEOUT);
                seen_q  <= seen_q | samp_mask;
                if (seen_q == 4'hF)
                    state_q <= CONVERT;
            end else begin
                bcd_q     <= {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
                value_q   <= value_d;
                dp_mask_q <= dpm_q;
                err_q     <= |er_q;
                valid_q   <= 1'b1;
                tmo_q     <= '0;
                stale_q   <= 1'b0;
                // A digit sampled on this edge belongs to the next frame.
                seen_q    <= samp_mask;
                state_q   <= SCAN;
            end
        end
    end

    assign bcd     = bcd_q;
    assign value   = value_q;
    assign dp_mask = dp_mask_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign stale   = stale_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed frames checked against a frame-level model every cycle.
module tb_sevenseg_capture;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 3000;
    localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AX = 4'b1111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    logic        clk = 1'b0, rst = 1'b1, dp = 1'b1;
    logic [0:6]  c = 7'h7F;
    logic [3:0]  d = 4'hF;
    logic [15:0] bcd;
    logic [13:0] value;
    logic [3:0]  dp_mask;
    logic        valid, err, stale;

    int checks = 0, failures = 0, cyc = 0, vat = -1, last_zero = 0, nvalid = 0, nv0 = 0;
    int          sd [4];
    logic [3:0]  sdp, ser, seen, prev_an = 4'hF;
    logic [15:0] p_bcd, e_bcd = '0;
    logic [13:0] p_val, e_val = '0;
    logic [3:0]  p_dpm, e_dpm = '0;
    logic        p_err, e_err = 1'b0, ev, e_stale;

    sevenseg_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .c(c), .d(d), .dp(dp),
        .bcd(bcd), .value(value), .dp_mask(dp_mask), .valid(valid), .err(err), .stale(stale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Frame model: digits land in slots; the fourth distinct digit closes the frame,
    // whose result appears two edges after that digit's sampling edge.
    task automatic model_sample(input logic [3:0] an, input logic [6:0] seg, input logic dpl);
        int i;
        i = (an == A0) ? 0 : (an == A1) ? 1 : (an == A2) ? 2 : 3;
        sd[i] = 0;
        ser[i] = 1'b1;
        for (int k = 0; k < 10; k++)
            if (seg == PAT[k]) begin
                sd[i] = k;
                ser[i] = 1'b0;
            end
        sdp[i] = !dpl;
        seen[i] = 1'b1;
        if (seen == 4'hF) begin
            p_bcd = 16'((sd[3] << 12) | (sd[2] << 8) | (sd[1] << 4) | sd[0]);
            p_val = 14'(sd[3] * 1000 + sd[2] * 100 + sd[1] * 10 + sd[0]);
            p_dpm = sdp;
            p_err = |ser;
            vat = cyc + 2;
            seen = 4'h0;
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input logic dpl, input int n);
        int s;
        bit smp;
        d = an;
        c = seg;
        dp = dpl;
        s = cyc;
        smp = ($countones(~an) == 1) && an != prev_an && n >= SETTLE;
        prev_an = an;
        repeat (n) begin
            @(posedge clk); #1;
            if (smp && cyc == s + SETTLE) model_sample(an, seg, dpl);
        end
    endtask

    task automatic frame(input int d3, input int d2, input int d1, input int d0, input logic [3:0] dpl);
        show(A3, PAT[d3], dpl[3], 100);
        show(A2, PAT[d2], dpl[2], 100);
        show(A1, PAT[d1], dpl[1], 100);
        show(A0, PAT[d0], dpl[0], 100);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        d = AX;
        c = BLANK;
        dp = 1'b1;
        prev_an = AX;
        seen = 4'h0;
        vat = -1;
        e_bcd = '0; e_val = '0; e_dpm = '0; e_err = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_outputs", {bcd, value, dp_mask, valid, err, stale}, 0);
        rst = 1'b0;
        last_zero = cyc;
    endtask

    task automatic res_chk(input string nm, input int nv, input logic [15:0] b, input logic [13:0] v,
                           input logic [3:0] m, input logic e);
        chk({nm, "_valids"}, 64'(nvalid - nv0), 64'(nv));
        chk({nm, "_bcd"}, bcd, b);
        chk({nm, "_value"}, value, v);
        chk({nm, "_dp_mask"}, dp_mask, m);
        chk({nm, "_err"}, err, e);
        nv0 = nvalid;
    endtask

    always @(negedge clk) begin
        if (rst) last_zero = cyc;
        ev = (cyc == vat);
        if (ev) begin
            e_bcd = p_bcd; e_val = p_val; e_dpm = p_dpm; e_err = p_err;
            last_zero = cyc;
        end
        e_stale = !rst && (cyc - last_zero >= TIMEOUT);
        nvalid += int'(valid);
        chk("cycle", {valid, bcd, value, dp_mask, err, stale}, {ev, e_bcd, e_val, e_dpm, e_err, e_stale});
    end

    initial begin
        do_reset();
        frame(1, 2, 3, 4, 4'b1111);
        res_chk("f1234", 1, 16'h1234, 14'd1234, 4'b0000, 1'b0);
        frame(1, 2, 3, 4, 4'b1011);
        res_chk("dp2", 1, 16'h1234, 14'd1234, 4'b0100, 1'b0);
        show(A3, PAT[1], 1'b1, 100);
        show(A2, PAT[2], 1'b1, 100);
        show(A1, BLANK, 1'b1, 100);
        show(A0, PAT[4], 1'b1, 100);
        res_chk("blank1", 1, 16'h1204, 14'd1204, 4'b0000, 1'b1);
        repeat (40) begin
            show(A3, PAT[1], 1'b1, SETTLE - 1);
            show(A2, PAT[2], 1'b1, SETTLE - 1);
            show(A1, PAT[3], 1'b1, SETTLE - 1);
            show(A0, PAT[4], 1'b1, SETTLE - 1);
        end
        repeat (4) begin
            show(4'b1100, PAT[6], 1'b1, 100);
            show(4'b0011, PAT[7], 1'b1, 100);
        end
        chk("stale_set", stale, 1);
        res_chk("nosample", 0, 16'h1204, 14'd1204, 4'b0000, 1'b1);
        frame(5, 6, 7, 8, 4'b1111);
        chk("stale_clr", stale, 0);
        res_chk("f5678", 1, 16'h5678, 14'd5678, 4'b0000, 1'b0);
        show(AX, BLANK, 1'b1, 5);
        show(A0, PAT[5], 1'b1, 100);
        show(A3, PAT[9], 1'b1, 100);
        show(A0, PAT[7], 1'b1, 100);
        show(A2, PAT[9], 1'b1, 100);
        show(A1, PAT[9], 1'b1, 100);
        res_chk("latest", 1, 16'h9997, 14'd9997, 4'b0000, 1'b0);
        show(A3, PAT[1], 1'b1, 100);
        show(A2, PAT[2], 1'b1, 100);
        do_reset();
        nv0 = nvalid;
        frame(0, 0, 0, 8, 4'b1111);
        res_chk("after_rst", 1, 16'h0008, 14'd8, 4'b0000, 1'b0);
        repeat (20) begin @(posedge clk); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side counterpart to the multiplexed four-digit seven-segment driver. Monitors the active-low segment bus `c`, anode bus `d` and decimal point `dp`, and reconstructs the displayed value as BCD digits and a 14-bit binary number. Used on the board as an in-system self-check of the ALU display path and in benches as a scoreboard front end. Publishes one `valid` pulse per complete frame, with a decode error flag and a stale-display flag.

## Interface
Parameters:
- `SETTLE`, 16: cycles a single-digit anode pattern must hold before its segments are sampled (≥2).
- `TIMEOUT`, 2_000_000: cycles without a completed frame before `stale` asserts.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `c`  in  [0:6]  segment bus, active-low; `c[0]` = segment a … `c[6]` = segment g.
- `d`  in  [3:0]  anode bus, active-low one-cold; `d[0]` = least significant digit.
- `dp`  in  1  decimal point, active-low.
- `bcd`  out  [15:0]  captured digits; `[3:0]` = digit 0 … `[15:12]` = digit 3.
- `value`  out  [13:0]  binary equivalent of `bcd`, 0–9999.
- `dp_mask`  out  [3:0]  bit n set if digit n had `dp` low in the captured frame.
- `valid`  out  1  one-cycle pulse; `bcd`/`value`/`dp_mask`/`err` updated that cycle.
- `err`  out  1  captured frame contained at least one undecodable pattern.
- `stale`  out  1  no complete frame for `TIMEOUT` cycles.

## Operation
- Reset values: `bcd`=0, `value`=0, `dp_mask`=0, `valid`=0, `err`=0, `stale`=0; seen mask, stability counter, timeout counter cleared; FSM in SCAN.
- Anode qualification: legal when exactly one bit of `d` is 0. Stability counter resets to 0 on any change of `d` or an illegal pattern; otherwise increments, saturating at `SETTLE`.
- Sample: on the cycle the counter reaches `SETTLE - 1`, register the pattern into that digit's slot: decoded digit, `~dp`, decode-error bit; set its seen bit. One sample per anode dwell; re-sampled only after `d` changes.
- Decode (active-low, `c[0:6]`): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any other pattern → digit 0 with error bit set.
- Re-visited digit before frame completion: slot overwritten, latest wins.
- FSM: SCAN → CONVERT when seen mask becomes 4'b1111 (checked the cycle after the sample). CONVERT: `value = d3*1000 + d2*100 + d1*10 + d0` (shift-add, 14-bit result, no overflow possible); load outputs, `err` = OR of slot error bits, pulse `valid`, clear seen mask, clear timeout counter → SCAN.
- Timeout counter increments every cycle in SCAN; at `TIMEOUT` sets `stale` and saturates. `stale` clears on the next `valid`.
- Outputs hold between `valid` pulses.

## Timing
- Sample latency: `SETTLE` cycles after `d` settles to a legal pattern.
- `valid` asserts 2 cycles after the sampling edge of the fourth distinct digit (1 cycle seen-mask register, 1 cycle CONVERT); outputs change on that same edge.
- Sampling edge of a new digit coinciding with CONVERT: the new sample is kept and counts toward the next frame.
- `rst` mid-frame: partial slots discarded immediately; no `valid` until four fresh digits are captured.
- Segment and anode changes on the same edge (driver behaviour) are tolerated by the settle window.

## Structure
- Shared package `sevenseg_pkg`: ten segment-pattern constants (shared with the display driver) and the four one-cold anode codes.
- Sub-module `seg_decode`: combinational 7-bit pattern → 4-bit digit + error flag; one instance muxed at the sample point.

## Test plan
- Drive frame 1,2,3,4 on digits 3..0, each anode held 100 cycles, `dp` high → one `valid`, `value`=1234, `bcd`=16'h1234, `dp_mask`=0, `err`=0.
- Same frame with `dp` low only on digit 2 → `dp_mask`=4'b0100, `value`=1234.
- Digit 1 pattern 7'b1111111 (blank) → `err`=1, `bcd`[7:4]=0.
- Anode held only `SETTLE-1` cycles per digit, or two anodes low → no `valid`; after `TIMEOUT` cycles `stale`=1; a good frame clears it.
- Digit 0 shown as 5 then 7 before digits 1–3 complete with 9,9,9 → `value`=9997.
- Assert `rst` after two digits captured, then show 0,0,0,8 → single `valid`, `value`=8, all outputs 0 during reset.
